// File: rtl/addsub_stream_n_if.sv
// rtl/addsub_stream_n_if.sv - FIFO-side signal bundle for the two-stream sample combiner
interface addsub_stream_n_if #(
  parameter int DATA_WIDTH = 32
);
  logic [1:0]                   mode;
  logic signed [DATA_WIDTH-1:0] x_in;
  logic                         x_in_empty;
  logic                         x_in_rd_en;
  logic signed [DATA_WIDTH-1:0] y_in;
  logic                         y_in_empty;
  logic                         y_in_rd_en;
  logic                         out_full;
  logic                         out_wr_en;
  logic signed [DATA_WIDTH-1:0] dout;
  logic                         sat_event;
  logic                         frame_done;

  // The combiner masters all three FIFOs: it pops X/Y and pushes the result.
  modport master (
    input  mode, x_in, x_in_empty, y_in, y_in_empty, out_full,
    output x_in_rd_en, y_in_rd_en, out_wr_en, dout, sat_event, frame_done
  );

  modport slave (
    output mode, x_in, x_in_empty, y_in, y_in_empty, out_full,
    input  x_in_rd_en, y_in_rd_en, out_wr_en, dout, sat_event, frame_done
  );
endinterface

// File: rtl/addsub_stream_n.sv
// rtl/addsub_stream_n.sv - pops paired X/Y samples, applies the frame's add/sub/avg mode, pushes result
module addsub_stream_n #(
  parameter int DATA_WIDTH    = 32,
  parameter int FRAME_SAMPLES = 10,
  parameter int SATURATE      = 1
) (
  input logic             clock,
  input logic             reset,
  addsub_stream_n_if.master bus
);
  localparam int IDXW = (FRAME_SAMPLES > 1) ? $clog2(FRAME_SAMPLES) : 1;
  localparam logic [IDXW-1:0]       LAST_IDX = IDXW'(FRAME_SAMPLES - 1);
  localparam logic [DATA_WIDTH-1:0] MAX_VAL  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_VAL  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic                         pend;
  logic                         hold_valid;
  logic [DATA_WIDTH-1:0]        hold_data;
  logic                         hold_sat;
  logic [IDXW-1:0]              rd_idx;
  logic [IDXW-1:0]              wr_idx;
  logic [1:0]                   frame_mode;
  logic                         frame_done_q;

  logic                         rd_en;
  logic                         wr_en;
  logic [DATA_WIDTH-1:0]        wr_data;
  logic                         wr_sat;
  logic signed [DATA_WIDTH:0]   xe;
  logic signed [DATA_WIDTH:0]   ye;
  logic signed [DATA_WIDTH:0]   wide;
  logic [DATA_WIDTH-1:0]        result;
  logic                         result_sat;

  // One extra bit holds any sum/difference exactly; overflow shows as top two bits differing.
  always_comb begin
    xe = {bus.x_in[DATA_WIDTH-1], bus.x_in};
    ye = {bus.y_in[DATA_WIDTH-1], bus.y_in};
    case (frame_mode)
      2'b00:   wide = xe + ye;
      2'b01:   wide = xe - ye;
      2'b10:   wide = ye - xe;
      default: wide = (xe + ye) >>> 1;
    endcase
    result     = wide[DATA_WIDTH-1:0];
    result_sat = 1'b0;
    if (SATURATE != 0 && (wide[DATA_WIDTH] != wide[DATA_WIDTH-1])) begin
      result     = wide[DATA_WIDTH] ? MIN_VAL : MAX_VAL;
      result_sat = 1'b1;
    end
  end

  // A read is only issued when its result is guaranteed somewhere to land next cycle.
  assign rd_en = !reset && !bus.x_in_empty && !bus.y_in_empty &&
                 (!hold_valid || !bus.out_full) && !(pend && bus.out_full);

  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    wr_sat  = 1'b0;
    if (!reset) begin
      if (hold_valid && !bus.out_full) begin
        wr_en   = 1'b1;
        wr_data = hold_data;
        wr_sat  = hold_sat;
      end else if (pend && !bus.out_full) begin
        wr_en   = 1'b1;
        wr_data = result;
        wr_sat  = result_sat;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend         <= 1'b0;
      hold_valid   <= 1'b0;
      hold_data    <= '0;
      hold_sat     <= 1'b0;
      rd_idx       <= '0;
      wr_idx       <= '0;
      frame_mode   <= 2'b00;
      frame_done_q <= 1'b0;
    end else begin
      pend <= rd_en;
      if (hold_valid && !bus.out_full) begin
        hold_valid <= 1'b0;
      end else if (pend && bus.out_full) begin
        hold_valid <= 1'b1;
        hold_data  <= result;
        hold_sat   <= result_sat;
      end
      if (rd_en) begin
        if (rd_idx == '0) begin
          frame_mode <= bus.mode;
        end
        rd_idx <= (rd_idx == LAST_IDX) ? '0 : rd_idx + 1'b1;
      end
      if (wr_en) begin
        wr_idx <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
      end
      frame_done_q <= wr_en && (wr_idx == LAST_IDX);
    end
  end

  assign bus.x_in_rd_en = rd_en;
  assign bus.y_in_rd_en = rd_en;
  assign bus.out_wr_en  = wr_en;
  assign bus.dout       = wr_data;
  assign bus.sat_event  = wr_sat;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_addsub_stream_n.sv
// tb/tb_addsub_stream_n.sv - randomized and directed bench for addsub_stream_n against a stream-level model
module tb_addsub_stream_n;
  localparam int W  = 8;
  localparam int FS = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  addsub_stream_n_if #(.DATA_WIDTH(W)) sbus ();
  addsub_stream_n_if #(.DATA_WIDTH(W)) wbus ();

  addsub_stream_n #(.DATA_WIDTH(W), .FRAME_SAMPLES(FS), .SATURATE(1)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (sbus.master)
  );

  addsub_stream_n #(.DATA_WIDTH(W), .FRAME_SAMPLES(FS), .SATURATE(0)) dut_wrap (
    .clock (clock),
    .reset (reset),
    .bus   (wbus.master)
  );

  // The wrapping instance sees exactly the same traffic as the saturating one.
  assign wbus.mode       = sbus.mode;
  assign wbus.x_in       = sbus.x_in;
  assign wbus.x_in_empty = sbus.x_in_empty;
  assign wbus.y_in       = sbus.y_in;
  assign wbus.y_in_empty = sbus.y_in_empty;
  assign wbus.out_full   = sbus.out_full;

  int n_checks = 0;
  int n_fail   = 0;

  int xq[$], yq[$];
  int exp_s[$], exp_sat[$], exp_w[$];
  int rd_cyc[$];
  int log_d[$], log_s[$], log_w[$], log_c[$];
  int n_reads, n_writes, cycle, fd_count;
  logic [1:0] cur_mode;
  bit exp_fd, rd_seen, lat_mode, full_force, xe_force, ye_force, rand_mode;
  int full_pct, empty_pct;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stream semantics in plain integer arithmetic.
  task automatic ref_calc(input int m, input int x, input int y, input bit sat,
                          output int r, output bit s);
    int v;
    int lo = -(1 << (W - 1));
    int hi = (1 << (W - 1)) - 1;
    case (m)
      0:       v = x + y;
      1:       v = x - y;
      2:       v = y - x;
      default: v = (x + y >= 0) ? (x + y) / 2 : -((-(x + y) + 1) / 2);
    endcase
    s = 1'b0;
    if (sat) begin
      if (v > hi) begin v = hi; s = 1'b1; end
      else if (v < lo) begin v = lo; s = 1'b1; end
      r = v;
    end else begin
      r = ((v % 256) + 256) % 256;
      if (r > hi) r = r - 256;
    end
  endtask

  task automatic sample();
    int r, rw, rc;
    bit s, sw;
    @(negedge clock);
    cycle++;
    check("rd_en_pair", sbus.x_in_rd_en, sbus.y_in_rd_en);
    check("rd_en_wrap", wbus.x_in_rd_en, sbus.x_in_rd_en);
    check("wr_en_wrap", wbus.out_wr_en, sbus.out_wr_en);
    check("pend_hold_excl", int'(dut.pend && dut.hold_valid), 0);
    check("frame_done", sbus.frame_done, exp_fd);
    check("frame_done_wrap", wbus.frame_done, exp_fd);
    if (sbus.frame_done) fd_count++;
    exp_fd = 1'b0;
    if (sbus.out_wr_en) begin
      check("wr_not_full", sbus.out_full, 0);
      if (exp_s.size() == 0) begin
        check("spurious_write", 1, 0);
      end else begin
        check("dout", sbus.dout, exp_s[0]);
        check("sat_event", sbus.sat_event, exp_sat[0]);
        check("dout_wrap", wbus.dout, exp_w[0]);
        check("sat_event_wrap", wbus.sat_event, 0);
        void'(exp_s.pop_front());
        void'(exp_sat.pop_front());
        void'(exp_w.pop_front());
      end
      log_d.push_back(sbus.dout);
      log_s.push_back(sbus.sat_event);
      log_w.push_back(wbus.dout);
      log_c.push_back(cycle);
      n_writes++;
      if (n_writes % FS == 0) exp_fd = 1'b1;
      if (rd_cyc.size() > 0) begin
        rc = rd_cyc.pop_front();
        if (lat_mode) check("latency", cycle - rc, 1);
      end
    end else begin
      check("dout_idle", sbus.dout, 0);
      check("sat_idle", sbus.sat_event, 0);
    end
    rd_seen = sbus.x_in_rd_en;
    if (rd_seen) begin
      check("rd_nonempty", int'(sbus.x_in_empty || sbus.y_in_empty), 0);
      if (n_reads % FS == 0) cur_mode = sbus.mode;
      if (xq.size() > 0 && yq.size() > 0) begin
        ref_calc(cur_mode, xq[0], yq[0], 1'b1, r, s);
        ref_calc(cur_mode, xq[0], yq[0], 1'b0, rw, sw);
        exp_s.push_back(r);
        exp_sat.push_back(int'(s));
        exp_w.push_back(rw);
      end
      n_reads++;
      rd_cyc.push_back(cycle);
    end
  endtask

  task automatic drive();
    @(posedge clock);
    #1;
    if (rd_seen && xq.size() > 0 && yq.size() > 0) begin
      sbus.x_in = W'(xq.pop_front());
      sbus.y_in = W'(yq.pop_front());
    end else begin
      sbus.x_in = W'($urandom);
      sbus.y_in = W'($urandom);
    end
    sbus.out_full   = full_force || (int'($urandom_range(99)) < full_pct);
    sbus.x_in_empty = (xq.size() == 0) || xe_force || (int'($urandom_range(99)) < empty_pct);
    sbus.y_in_empty = (yq.size() == 0) || ye_force || (int'($urandom_range(99)) < empty_pct);
    if (rand_mode) sbus.mode = 2'($urandom_range(3));
  endtask

  task automatic step();
    sample();
    drive();
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((xq.size() > 0 || yq.size() > 0 || exp_s.size() > 0) && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) check("drain_timeout", 1, 0);
    repeat (2) step();
  endtask

  task automatic clear_logs();
    log_d.delete(); log_s.delete(); log_w.delete(); log_c.delete();
    fd_count = 0;
  endtask

  task automatic run_frame(input logic [1:0] m, input int xs[4], input int ys[4]);
    sbus.mode = m;
    for (int i = 0; i < 4; i++) begin
      xq.push_back(xs[i]);
      yq.push_back(ys[i]);
    end
    drain(200);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"}, int'(sbus.x_in_rd_en | sbus.y_in_rd_en), 0);
    check({tag, "_wr_en"}, int'(sbus.out_wr_en | wbus.out_wr_en), 0);
    check({tag, "_dout"}, sbus.dout, 0);
    check({tag, "_sat"}, sbus.sat_event, 0);
    check({tag, "_frame_done"}, sbus.frame_done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r0, w0, k;
    reset = 1'b1;
    sbus.mode = 2'b00; sbus.x_in = '0; sbus.y_in = '0;
    sbus.x_in_empty = 1'b1; sbus.y_in_empty = 1'b1; sbus.out_full = 1'b0;
    n_reads = 0; n_writes = 0; cycle = 0; fd_count = 0; cur_mode = 2'b00;
    exp_fd = 0; rd_seen = 0; lat_mode = 0; full_force = 0; xe_force = 0; ye_force = 0;
    rand_mode = 0; full_pct = 0; empty_pct = 0;

    // Reset state
    repeat (2) @(negedge clock);
    check_outputs_zero("reset");
    @(posedge clock); #1;
    reset = 1'b0;

    // 1: subtract, back-to-back, one cycle latency
    clear_logs();
    lat_mode = 1'b1;
    run_frame(2'b01, '{10, -5, 0, 0}, '{3, 4, 0, 0});
    lat_mode = 1'b0;
    check("t1_d0", log_d[0], 7);
    check("t1_d1", log_d[1], -9);
    check("t1_consecutive", log_c[1] - log_c[0], 1);

    // 2: saturation vs wrap
    clear_logs();
    run_frame(2'b00, '{100, -100, 5, 0}, '{100, -100, 6, 0});
    run_frame(2'b01, '{-128, 127, 0, 0}, '{1, -1, 0, 0});
    check("t2_sat_pos", log_d[0], 127);
    check("t2_sat_pos_flag", log_s[0], 1);
    check("t2_wrap_pos", log_w[0], -56);
    check("t2_wrap_neg", log_w[1], 56);
    check("t2_sub_clamp", log_d[4], -128);
    check("t2_sub_clamp_flag", log_s[4], 1);
    check("t2_sub_wrap", log_w[4], 127);

    // 3: average floors and never clamps; reverse subtract
    clear_logs();
    run_frame(2'b11, '{-3, 127, -128, 1}, '{0, 127, -128, 0});
    run_frame(2'b10, '{3, 0, 0, 0}, '{10, 0, 0, 0});
    check("t3_avg_floor", log_d[0], -2);
    check("t3_avg_max", log_d[1], 127);
    check("t3_avg_max_flag", log_s[1], 0);
    check("t3_avg_min", log_d[2], -128);
    check("t3_rev_sub", log_d[4], 7);

    // 4: hold register under backpressure
    clear_logs();
    sbus.mode = 2'b00;
    full_force = 1'b1;
    for (int i = 1; i <= 4; i++) begin xq.push_back(i); yq.push_back(0); end
    r0 = n_reads; w0 = n_writes;
    repeat (6) step();
    check("t4_reads_while_full", n_reads - r0, 1);
    check("t4_writes_while_full", n_writes - w0, 0);
    check("t4_hold_valid", dut.hold_valid, 1);
    full_force = 1'b0;
    drain(200);
    for (int i = 0; i < 4; i++) check("t4_order", log_d[i], i + 1);

    // 4: random samples, random full/empty, random mode input
    clear_logs();
    rand_mode = 1'b1; full_pct = 30; empty_pct = 20;
    w0 = n_writes;
    for (int i = 0; i < 24; i++) begin
      xq.push_back(int'($urandom_range(255)) - 128);
      yq.push_back(int'($urandom_range(255)) - 128);
    end
    drain(3000);
    rand_mode = 1'b0; full_pct = 0; empty_pct = 0;
    check("t4_rand_count", n_writes - w0, 24);
    repeat (2) step();

    // 5: mode change mid-frame is ignored
    clear_logs();
    sbus.mode = 2'b00;
    for (int i = 0; i < 5; i++) begin xq.push_back(10); yq.push_back(3); end
    r0 = n_reads; k = 0;
    while (n_reads - r0 < 2 && k < 50) begin step(); k++; end
    check("t5_two_reads", n_reads - r0, 2);
    sbus.mode = 2'b01;
    drain(200);
    for (int i = 0; i < 4; i++) check("t5_frame_add", log_d[i], 13);
    check("t5_next_frame_sub", log_d[4], 7);
    check("t5_frame_done_count", fd_count, 1);

    // 6: one FIFO empty blocks both reads; reset with hold pending
    clear_logs();
    ye_force = 1'b1;
    xq.push_back(1); yq.push_back(1);
    xq.push_back(2); yq.push_back(2);
    r0 = n_reads;
    repeat (4) step();
    check("t6_no_read_y_empty", n_reads - r0, 0);
    ye_force = 1'b0; full_force = 1'b1;
    k = 0;
    while (!dut.hold_valid && k < 20) begin step(); k++; end
    check("t6_hold_reached", dut.hold_valid, 1);
    full_force = 1'b0;
    sbus.out_full = 1'b0;
    #1;
    check("t6_pre_reset_wr", sbus.out_wr_en, 1);
    reset = 1'b1;
    #1;
    check_outputs_zero("t6_reset");
    xq.delete(); yq.delete();
    exp_s.delete(); exp_sat.delete(); exp_w.delete(); rd_cyc.delete();
    n_reads = 0; n_writes = 0; exp_fd = 1'b0; rd_seen = 1'b0;
    sbus.x_in_empty = 1'b1; sbus.y_in_empty = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    clear_logs();
    run_frame(2'b01, '{9, 9, 9, 9}, '{4, 4, 4, 4});
    check("t6_new_frame_mode", log_d[0], 5);
    check("t6_new_frame_done", fd_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
